// File: rtl/event_sched_ctrl.sv
// Sequences DVS events into the accelerator: stamps t/addr, runs the ip_en/ip_done
// handshake per event, then ip_clean/ip_clear at end of sample; watchdog on both waits.
module event_sched_ctrl #(
  parameter int          EVENTS_PER_SAMPLE = 26,
  parameter logic [31:0] BASE_ADDR         = 32'h1000_0000,
  parameter logic [31:0] ADDR_STRIDE       = 32'h0000_0080,
  parameter int          GAP_CYCLES        = 5,
  parameter int          TIMEOUT_CYCLES    = 4096,
  parameter int          X_PIXEL_WIDTH     = 8,
  parameter int          Y_PIXEL_WIDTH     = 8,
  parameter int          T_WIDTH           = 8
) (
  input  logic                                              clk,
  input  logic                                              rstn,
  input  logic                                              ev_valid,
  output logic                                              ev_ready,
  input  logic [X_PIXEL_WIDTH-1:0]                          ev_x,
  input  logic [Y_PIXEL_WIDTH-1:0]                          ev_y,
  input  logic                                              ev_p,
  input  logic                                              flush,
  output logic [X_PIXEL_WIDTH+Y_PIXEL_WIDTH+T_WIDTH+33:0]   new_event,
  output logic                                              ip_en,
  input  logic                                              ip_done,
  input  logic                                              ip_idle,
  output logic                                              ip_clean,
  input  logic                                              ip_clear,
  input  logic                                              prediction,
  input  logic [1:0][31:0]                                  fc_out_pack,
  output logic                                              res_valid,
  output logic                                              res_pred,
  output logic [1:0][31:0]                                  res_logits,
  output logic                                              busy,
  output logic                                              err_timeout
);

  localparam int NE_W  = X_PIXEL_WIDTH + Y_PIXEL_WIDTH + T_WIDTH + 34;
  localparam int CNT_W = $clog2(EVENTS_PER_SAMPLE + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [CNT_W-1:0] EPS_C    = CNT_W'(EVENTS_PER_SAMPLE);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_CLEAN = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] ev_cnt_q, ev_cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             flush_pend_q, flush_pend_d;
  logic             ip_done_q, ip_clear_q;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [NE_W-1:0]  ne_q, ne_d;
  logic             ip_en_q, ip_en_d;
  logic             ip_clean_q, ip_clean_d;
  logic             res_valid_q, res_valid_d;
  logic             res_pred_q, res_pred_d;
  logic [1:0][31:0] res_logits_q, res_logits_d;
  logic             err_q, err_d;

  logic done_rise, clear_rise, accept, sample_end;

  assign ev_ready   = (state_q == S_IDLE) && !flush_pend_q && (ev_cnt_q < EPS_C);
  assign accept     = ev_valid && ev_ready;
  assign done_rise  = ip_done && !ip_done_q;
  assign clear_rise = ip_clear && !ip_clear_q;
  assign sample_end = (ev_cnt_q == EPS_C) || (flush_pend_q && (ev_cnt_q != '0));

  always_comb begin
    state_d      = state_q;
    ev_cnt_d     = ev_cnt_q;
    addr_d       = addr_q;
    flush_pend_d = flush_pend_q;
    gap_d        = '0;
    wd_d         = '0;
    ne_d         = ne_q;
    ip_en_d      = ip_en_q;
    ip_clean_d   = ip_clean_q;
    res_valid_d  = 1'b0;
    res_pred_d   = res_pred_q;
    res_logits_d = res_logits_q;
    err_d        = err_q;

    // A flush with nothing accumulated has no sample to end, so it is dropped.
    if (flush && (state_q != S_CLEAN) && !((state_q == S_IDLE) && (ev_cnt_q == '0)))
      flush_pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          ne_d    = {1'b1, ev_x, ev_y, ev_p, T_WIDTH'(ev_cnt_q), addr_q};
          state_d = S_SETUP;
        end else if (sample_end) begin
          state_d     = S_CLEAN;
          ip_clean_d  = 1'b1;
          res_valid_d = 1'b1;
        end
      end
      S_SETUP: begin
        // A still-high ip_done from the last event would mask the next rise.
        if (ip_idle && !ip_done) begin
          state_d = S_RUN;
          ip_en_d = 1'b1;
        end
      end
      S_RUN: begin
        wd_d = wd_q + 1'b1;
        if (done_rise) begin
          ip_en_d      = 1'b0;
          res_pred_d   = prediction;
          res_logits_d = fc_out_pack;
          ev_cnt_d     = ev_cnt_q + 1'b1;
          addr_d       = addr_q + ADDR_STRIDE;
          state_d      = S_GAP;
          wd_d         = '0;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          ip_en_d = 1'b0;
          state_d = S_IDLE;
          wd_d    = '0;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (sample_end) begin
            state_d     = S_CLEAN;
            ip_clean_d  = 1'b1;
            res_valid_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_CLEAN: begin
        wd_d = wd_q + 1'b1;
        if (clear_rise || (wd_q == WD_LAST)) begin
          if (!clear_rise) err_d = 1'b1;
          ip_clean_d   = 1'b0;
          ev_cnt_d     = '0;
          addr_d       = BASE_ADDR;
          flush_pend_d = 1'b0;
          state_d      = S_IDLE;
          wd_d         = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      ev_cnt_q     <= '0;
      addr_q       <= BASE_ADDR;
      flush_pend_q <= 1'b0;
      ip_done_q    <= 1'b0;
      ip_clear_q   <= 1'b0;
      gap_q        <= '0;
      wd_q         <= '0;
      ne_q         <= '0;
      ip_en_q      <= 1'b0;
      ip_clean_q   <= 1'b0;
      res_valid_q  <= 1'b0;
      res_pred_q   <= 1'b0;
      res_logits_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ev_cnt_q     <= ev_cnt_d;
      addr_q       <= addr_d;
      flush_pend_q <= flush_pend_d;
      ip_done_q    <= ip_done;
      ip_clear_q   <= ip_clear;
      gap_q        <= gap_d;
      wd_q         <= wd_d;
      ne_q         <= ne_d;
      ip_en_q      <= ip_en_d;
      ip_clean_q   <= ip_clean_d;
      res_valid_q  <= res_valid_d;
      res_pred_q   <= res_pred_d;
      res_logits_q <= res_logits_d;
      err_q        <= err_d;
    end
  end

  assign new_event   = ne_q;
  assign ip_en       = ip_en_q;
  assign ip_clean    = ip_clean_q;
  assign res_valid   = res_valid_q;
  assign res_pred    = res_pred_q;
  assign res_logits  = res_logits_q;
  assign busy        = (state_q != S_IDLE);
  assign err_timeout = err_q;

endmodule

// File: tb/tb_event_sched_ctrl.sv
// Bench for event_sched_ctrl: accelerator model, new_event scoreboard, event tables
// and hand-written sequences for flush, back-pressure, watchdog and reset.
module tb_event_sched_ctrl;

  localparam logic [31:0] BASE    = 32'h1000_0000;
  localparam logic [31:0] STRIDE  = 32'h0000_0080;
  localparam int          DONE_AT = 21;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             ev_valid = 1'b0;
  logic             ev_ready;
  logic [7:0]       ev_x = '0, ev_y = '0;
  logic             ev_p = 1'b0;
  logic             flush = 1'b0;
  logic [57:0]      new_event;
  logic             ip_en, ip_clean;
  logic             ip_done = 1'b0, ip_idle = 1'b1, ip_clear = 1'b0;
  logic             prediction = 1'b0;
  logic [1:0][31:0] fc_out_pack = '0;
  logic             res_valid, res_pred, busy, err_timeout;
  logic [1:0][31:0] res_logits;

  event_sched_ctrl #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rstn(rstn), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_x(ev_x), .ev_y(ev_y), .ev_p(ev_p), .flush(flush), .new_event(new_event),
    .ip_en(ip_en), .ip_done(ip_done), .ip_idle(ip_idle), .ip_clean(ip_clean),
    .ip_clear(ip_clear), .prediction(prediction), .fc_out_pack(fc_out_pack),
    .res_valid(res_valid), .res_pred(res_pred), .res_logits(res_logits),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  x;
    logic [7:0]  y;
    logic        p;
    logic [7:0]  t;
    logic [31:0] addr;
  } ev_t;

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic        p;
    logic [7:0]  t;
    logic [31:0] addr;
  } vec_t;

  ev_t  exp_q[$];
  vec_t tbl[26];

  int checks = 0, failures = 0;
  int cyc = 0, en_len = 0, last_en_len = 0, overlap = 0, rv_cnt = 0, clean_rises = 0;
  int acc_cnt = 0, cl_cnt = 0, clear_rise_cyc = 0, clean_fall_cyc = 0;
  logic en_prev = 1'b0, clean_prev = 1'b0, done_en = 1'b1;
  logic             model_pred = 1'b0;
  logic [1:0][31:0] model_logits = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (wait bound expired)", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Monitor, scoreboard and accelerator model share one process so their order is fixed.
  always @(posedge clk) begin
    ev_t e;
    #1;
    cyc++;
    if (ip_en && !en_prev) begin
      if (exp_q.size() == 0) fail_now("new_event_unexpected");
      else begin
        e = exp_q.pop_front();
        chk("new_event", 64'(new_event), 64'({1'b1, e.x, e.y, e.p, e.t, e.addr}));
      end
    end
    if (ip_en) en_len++;
    else if (en_prev) begin
      last_en_len = en_len;
      en_len = 0;
    end
    en_prev = ip_en;
    if (ip_en && ip_clean) overlap++;
    if (res_valid) rv_cnt++;
    if (ip_clean && !clean_prev) clean_rises++;
    if (!ip_clean && clean_prev) clean_fall_cyc = cyc;
    clean_prev = ip_clean;
    if (ip_en) begin
      acc_cnt++;
      if (done_en && acc_cnt == DONE_AT) begin
        model_pred      = 1'($urandom_range(0, 1));
        model_logits[0] = $urandom;
        model_logits[1] = $urandom;
        prediction      = model_pred;
        fc_out_pack     = model_logits;
        ip_done         = 1'b1;
      end
    end else begin
      acc_cnt = 0;
      ip_done = 1'b0;
    end
    if (ip_clean) begin
      cl_cnt++;
      if (cl_cnt == 3) begin
        ip_clear = 1'b1;
        clear_rise_cyc = cyc;
      end
    end else begin
      cl_cnt = 0;
      ip_clear = 1'b0;
    end
  end

  task automatic send_event(input logic [7:0] x, input logic [7:0] y, input logic p,
                            input logic [7:0] et, input logic [31:0] ea);
    int n = 0;
    ev_x = x; ev_y = y; ev_p = p; ev_valid = 1'b1;
    while (!ev_ready && n < 300) begin tick(); n++; end
    if (!ev_ready) begin
      fail_now("accept");
      ev_valid = 1'b0;
      return;
    end
    exp_q.push_back({x, y, p, et, ea});
    tick();
    ev_valid = 1'b0;
  endtask

  task automatic wait_en_cycle();
    int n = 0;
    while (!ip_en && n < 100) begin tick(); n++; end
    if (!ip_en) fail_now("ip_en_rise");
    n = 0;
    while (ip_en && n < 300) begin tick(); n++; end
    if (ip_en) fail_now("ip_en_fall");
  endtask

  task automatic count_gap(input string name);
    int n = 0;
    while (!ev_ready && n < 50) begin tick(); n++; end
    chk(name, 64'(n), 64'(5));
  endtask

  task automatic expect_clean(input string name, input int exp_wait);
    int n = 0;
    while (!ip_clean && n < 100) begin tick(); n++; end
    chk({name, "_clean_wait"}, 64'(n), 64'(exp_wait));
    chk({name, "_res_valid"}, 64'(res_valid), 64'(1));
    chk({name, "_res_pred"}, 64'(res_pred), 64'(model_pred));
    chk({name, "_res_logits"}, res_logits, model_logits);
    n = 0;
    while (ip_clean && n < 100) begin tick(); n++; end
    if (ip_clean) fail_now({name, "_clean_fall"});
    chk({name, "_clean_drop"}, 64'(clean_fall_cyc - clear_rise_cyc), 64'(1));
    chk({name, "_ready_after"}, 64'(ev_ready), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation stalled");
  end

  initial begin
    int k, cr, rv0;
    logic seen;
    k = 0;
    for (int dy = -3; dy <= 3; dy++)
      for (int dx = -3; dx <= 3; dx++)
        if (((dx < 0) ? -dx : dx) + ((dy < 0) ? -dy : dy) <= 3) begin
          tbl[k].x = 8'(10 + dx);
          tbl[k].y = 8'(10 + dy);
          k++;
        end
    tbl[25].x = 8'd14;
    tbl[25].y = 8'd10;
    for (int i = 0; i < 26; i++) begin
      tbl[i].p    = 1'(i);
      tbl[i].t    = 8'(i);
      tbl[i].addr = BASE + 32'(i) * STRIDE;
    end

    // Reset state
    repeat (3) tick();
    rstn = 1'b1;
    chk("rst_ip_en", 64'(ip_en), 64'(0));
    chk("rst_ip_clean", 64'(ip_clean), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_new_event", 64'(new_event), 64'(0));
    chk("rst_err", 64'(err_timeout), 64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_ev_ready", 64'(ev_ready), 64'(1));

    // Flush with an empty sample is dropped
    cr = clean_rises;
    flush = 1'b1; tick(); flush = 1'b0;
    repeat (10) tick();
    chk("flush0_no_clean", 64'(clean_rises), 64'(cr));
    chk("flush0_ready", 64'(ev_ready), 64'(1));

    // Single event
    send_event(8'd10, 8'd10, 1'b1, 8'd0, BASE);
    wait_en_cycle();
    chk("single_en_len", 64'(last_en_len), 64'(21));
    count_gap("single_gap");
    chk("single_res_pred", 64'(res_pred), 64'(model_pred));
    chk("single_res_logits", res_logits, model_logits);

    // Flush in IDLE with one event accumulated
    flush = 1'b1; tick(); flush = 1'b0;
    expect_clean("flush1", 1);

    // Full sample from the diamond table
    rv0 = rv_cnt;
    for (int i = 0; i < 26; i++) send_event(tbl[i].x, tbl[i].y, tbl[i].p, tbl[i].t, tbl[i].addr);
    wait_en_cycle();
    expect_clean("full", 5);
    chk("full_res_valid_once", 64'(rv_cnt - rv0), 64'(1));

    // Early flush during event 3
    for (int i = 0; i < 3; i++) send_event(8'(20 + i), 8'd5, 1'b0, 8'(i), BASE + 32'(i) * STRIDE);
    send_event(8'd30, 8'd6, 1'b1, 8'd3, BASE + 32'h180);
    k = 0;
    while (!ip_en && k < 100) begin tick(); k++; end
    repeat (3) tick();
    flush = 1'b1; tick(); flush = 1'b0;
    wait_en_cycle();
    chk("flush_ev3_not_aborted", 64'(last_en_len), 64'(21));
    expect_clean("flush3", 5);

    // ip_idle back-pressure
    ip_idle = 1'b0;
    send_event(8'd3, 8'd4, 1'b1, 8'd0, BASE);
    seen = 1'b0;
    repeat (10) begin tick(); if (ip_en) seen = 1'b1; end
    chk("bp_no_en", 64'(seen), 64'(0));
    chk("bp_busy", 64'(busy), 64'(1));
    ip_idle = 1'b1;
    chk("bp_en_still_low", 64'(ip_en), 64'(0));
    tick();
    chk("bp_en_next", 64'(ip_en), 64'(1));
    wait_en_cycle();
    count_gap("bp_gap");

    // Watchdog: ip_done never rises
    done_en = 1'b0;
    send_event(8'd7, 8'd7, 1'b0, 8'd1, BASE + STRIDE);
    wait_en_cycle();
    chk("wd_en_len", 64'(last_en_len), 64'(64));
    chk("wd_err", 64'(err_timeout), 64'(1));
    chk("wd_busy", 64'(busy), 64'(0));
    chk("wd_ready", 64'(ev_ready), 64'(1));
    done_en = 1'b1;
    send_event(8'd7, 8'd8, 1'b1, 8'd1, BASE + STRIDE);
    wait_en_cycle();
    chk("wd_retry_en_len", 64'(last_en_len), 64'(21));
    chk("wd_err_sticky", 64'(err_timeout), 64'(1));
    count_gap("wd_gap");

    // Reset while ip_en is high
    send_event(8'd9, 8'd9, 1'b1, 8'd2, BASE + 32'h100);
    k = 0;
    while (!ip_en && k < 100) begin tick(); k++; end
    repeat (3) tick();
    chk("mid_en_high", 64'(ip_en), 64'(1));
    rstn = 1'b0; tick(); rstn = 1'b1;
    chk("mid_rst_ip_en", 64'(ip_en), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_new_event", 64'(new_event), 64'(0));
    chk("mid_rst_err", 64'(err_timeout), 64'(0));
    chk("mid_rst_logits", res_logits, 64'(0));
    send_event(8'd1, 8'd2, 1'b0, 8'd0, BASE);
    wait_en_cycle();
    chk("mid_after_en_len", 64'(last_en_len), 64'(21));

    repeat (10) tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    chk("en_clean_overlap", 64'(overlap), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
